// File: rtl/lsu_unit.sv
// Load/store unit: runs one data-memory transaction per start over a req/ack handshake.
// Checks legality up front (misaligned or illegal funct3 never reaches memory), generates
// byte strobes and lane-replicated store data, aligns and extends load data, and aborts a
// request that sees no ack within TIMEOUT cycles.
//
// Ports:
//   clk, areset_n                 clock, asynchronous active-low reset
//   start, is_store, funct3       operation launch (sampled only when idle)
//   addr, store_data              effective address and store source
//   busy, done, err, rdata        status and extended load result
//   mem_req/we/addr/wstrb/wdata   memory request side
//   mem_ack, mem_rdata            memory response side
module lsu_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Legality of the incoming request.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Strobes and replicated data for the incoming store; loads never assert strobes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << addr[1:0];
        wdata_rep = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << addr[1:0];
        wdata_rep = {2{store_data[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = store_data;
      end
    endcase
    if (!is_store) strb = 4'b0000;
  end

  // Align the addressed lane to bit 0, then extend per the latched width code.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          we_d     = is_store;
          funct3_d = funct3;
          off_d    = addr[1:0];
          addr_d   = {addr[31:2], 2'b00};
          wdata_d  = wdata_rep;
          wstrb_d  = strb;
          cnt_d    = 8'd0;
          if (legal) begin
            state_d = StReq;
          end else begin
            state_d = StErr;
            rdata_d = 32'h0;
          end
        end
      end
      StReq: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (mem_ack) begin
          if (!we_q) rdata_d = load_ext;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decode registered state only.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StResp) || (state_q == StErr);
  assign err       = (state_q == StErr);
  assign mem_req   = (state_q == StReq);
  assign mem_we    = we_q & mem_req;
  assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized operations compared
// against an arithmetic reference model of the access rules.
module tb_lsu_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_model = 32'h0;

  // Chained-op operands used when an op hands off to the next in its done cycle.
  logic        chain = 1'b0;
  logic        nxt_st;
  logic [2:0]  nxt_f3;
  logic [31:0] nxt_a, nxt_sd;

  lsu_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------------------
  function automatic bit m_legal(input bit st, input int unsigned f3, input int unsigned a);
    if (st && f3 > 2) return 0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 0;
    if (f3 == 2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic int unsigned m_wstrb(input bit st, input int unsigned f3,
                                          input int unsigned a);
    if (!st) return 0;
    if (f3 == 0) return 1 << (a % 4);
    if (f3 == 1) return 3 << (a % 4);
    return 15;
  endfunction

  function automatic int unsigned m_wdata(input int unsigned f3, input int unsigned d);
    if (f3 == 0) return (d % 256) * 32'h01010101;
    if (f3 == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic int unsigned m_load(input int unsigned f3, input int unsigned a,
                                         input int unsigned w);
    int unsigned v;
    v = w >> (8 * (a % 4));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  // ---- one operation ---------------------------------------------------------------
  // ack_at: REQ cycle (1-based) in which mem_ack is driven; 0 or >TIMEOUT means never.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int ack_at, input logic [31:0] mrd,
                        input bit pre_started, input bit poke);
    bit legal;
    int reqs;
    bit acked;
    legal = m_legal(st, f3, a);
    acked = (ack_at >= 1) && (ack_at <= int'(TIMEOUT));
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    end
    @(posedge clk); #1;
    // Scramble inputs: the DUT must work from latched operands.
    start = 1'b0;
    is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    if (!legal) begin
      check_eq("ill_req", 32'(mem_req), 0);
      check_eq("ill_done", 32'(done), 1);
      check_eq("ill_err", 32'(err), 1);
      check_eq("ill_rdata", rdata, 0);
      rd_model = 32'h0;
    end else begin
      reqs = 0;
      while (mem_req && reqs < int'(TIMEOUT) + 2) begin
        reqs++;
        check_eq("req_busy", 32'(busy), 1);
        if (reqs == 1) begin
          check_eq("req_addr", mem_addr, (a / 4) * 4);
          check_eq("req_we", 32'(mem_we), 32'(st));
          check_eq("req_wstrb", 32'(mem_wstrb), m_wstrb(st, f3, a));
          if (st) check_eq("req_wdata", mem_wdata, m_wdata(f3, sd));
        end
        if (poke) start = 1'($urandom);
        mem_ack = (reqs == ack_at);
        mem_rdata = (reqs == ack_at) ? mrd : $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        start = 1'b0;
      end
      check_eq("req_cycles", reqs, acked ? ack_at : int'(TIMEOUT));
      check_eq("done", 32'(done), 1);
      check_eq("err", 32'(err), acked ? 0 : 1);
      if (!acked) rd_model = 32'h0;
      else if (!st) rd_model = m_load(f3, a, mrd);
      check_eq("rdata", rdata, rd_model);
    end
    if (chain) begin
      start = 1'b1; is_store = nxt_st; funct3 = nxt_f3; addr = nxt_a; store_data = nxt_sd;
    end
    @(posedge clk); #1;
    check_eq("idle_done", 32'(done), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_req", 32'(mem_req), 0);
    check_eq("idle_rdata", rdata, rd_model);
  endtask

  initial begin
    // Reset state.
    #3;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_req", 32'(mem_req), 0);
    check_eq("rst_we", 32'(mem_we), 0);
    check_eq("rst_wstrb", 32'(mem_wstrb), 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    @(negedge clk); areset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed scenarios.
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234, 1'b0, 1'b0);       // LB
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_1234, 1'b0, 1'b0);       // LBU
    run_op(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, 1'b0);       // SH
    run_op(1'b0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1'b0, 1'b0);                 // LW misaligned
    run_op(1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b0, 1'b0);                // bad funct3
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 1'b0, 1'b0);                // timeout
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 4, 32'h1234_5678, 1'b0, 1'b0);        // ack at limit
    run_op(1'b1, 3'b011, 32'h20, 32'h1, 1, 32'h0, 1'b0, 1'b0);                // bad store

    // Start poked during REQ is ignored; start in the done cycle chains the next op.
    chain = 1'b1;
    nxt_st = 1'b0; nxt_f3 = 3'b001; nxt_a = 32'h32; nxt_sd = 32'h0;
    run_op(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 3, 32'h0, 1'b0, 1'b1);
    chain = 1'b0;
    check_eq("chain_gap_busy", 32'(busy), 0);
    run_op(1'b0, 3'b001, 32'h32, 32'h0, 2, 32'h8001_7FFF, 1'b1, 1'b0);

    // Asynchronous reset mid-REQ.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("pre_rst_req", 32'(mem_req), 1);
    @(posedge clk); #3;
    areset_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(mem_req), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_done", 32'(done), 0);
    check_eq("arst_rdata", rdata, 0);
    rd_model = 32'h0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); areset_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check_eq("late_ack_done", 32'(done), 0);
    check_eq("late_ack_busy", 32'(busy), 0);
    check_eq("late_ack_req", 32'(mem_req), 0);
    run_op(1'b0, 3'b101, 32'h46, 32'h0, 1, 32'hA5C3_1122, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom);
      f3 = 3'($urandom);
      // Bias toward legal width codes so most ops reach memory.
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
      if (!st && $urandom_range(0, 2) == 0) f3 = 3'($urandom_range(4, 5));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      run_op(st, f3, a, $urandom, $urandom_range(0, TIMEOUT), $urandom, 1'b0,
             1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
